// File: rtl/klein_pkg.sv
// Shared definitions for the KLEIN round sequencer: state encoding, legal round counts
// and the per-CPR datapath/key-schedule select tables.
package klein_pkg;

   typedef logic [1:0] klein_state_t;

   localparam klein_state_t StIdle = 2'd0;
   localparam klein_state_t StRun  = 2'd1;
   localparam klein_state_t StDone = 2'd2;

   localparam int unsigned NR_KLEIN64 = 12;
   localparam int unsigned NR_KLEIN80 = 16;
   localparam int unsigned NR_KLEIN96 = 20;

   // Entries are {sels[3:0], selk[4:0]} indexed by phase.
   localparam logic [8:0] SEL_TABLE_2 [2] = '{9'b0111_00000, 9'b0000_10110};

   localparam logic [8:0] SEL_TABLE_4 [4] = '{
      9'b0111_00000, 9'b1001_10011, 9'b0111_11100, 9'b0000_10110
   };

   localparam logic [8:0] SEL_TABLE_8 [8] = '{
      9'b0111_00000, 9'b1011_01000, 9'b1001_10011, 9'b0000_10010,
      9'b0111_11100, 9'b0011_10110, 9'b0001_10110, 9'b0000_10110
   };

   function automatic logic nr_legal(int unsigned nr);
      return (nr == NR_KLEIN64) || (nr == NR_KLEIN80) || (nr == NR_KLEIN96);
   endfunction

   function automatic logic cpr_legal(int unsigned cpr);
      return (cpr == 2) || (cpr == 4) || (cpr == 8) || (cpr == 16);
   endfunction

   // CPR=16 spends two cycles on each CPR=8 step.
   function automatic logic [8:0] sel_lookup(int unsigned cpr, logic [3:0] phase);
      case (cpr)
         2:       return SEL_TABLE_2[phase[0]];
         4:       return SEL_TABLE_4[phase[1:0]];
         8:       return SEL_TABLE_8[phase[2:0]];
         16:      return SEL_TABLE_8[phase[3:1]];
         default: return '0;
      endcase
   endfunction

endpackage

// File: rtl/klein_mod_counter.sv
// Modulo-MOD up-counter with synchronous clear and enable; wrap flags the enabled
// terminal count.
module klein_mod_counter #(
   parameter int unsigned MOD = 8,
   parameter int unsigned W   = (MOD > 1) ? $clog2(MOD) : 1
) (
   input  logic         ck,
   input  logic         rst,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] count,
   output logic         wrap
);

   localparam logic [W-1:0] LAST = W'(MOD - 1);

   assign wrap = en && (count == LAST);

   always_ff @(posedge ck) begin
      if (rst || clr) begin
         count <= '0;
      end else if (en) begin
         count <= wrap ? '0 : count + W'(1);
      end
   end

endmodule

// File: rtl/klein_round_sequencer.sv
// KLEIN round sequencer: walks rounds 0..NR (NR = final whitening) at CPR cycles per
// round and drives phase-indexed datapath and key-schedule selects.
module klein_round_sequencer
   import klein_pkg::*;
#(
   parameter int unsigned NR  = 16,
   parameter int unsigned CPR = 8
) (
   input  logic                       ck,
   input  logic                       rst,
   input  logic                       start,
   input  logic                       abort,
   output logic                       busy,
   output logic                       done,
   output logic [$clog2(NR+1)-1:0]    round,
   output logic [$clog2(CPR)-1:0]     phase,
   output logic                       round0,
   output logic                       round1,
   output logic                       last_round,
   output logic [3:0]                 sels,
   output logic [4:0]                 selk
);

   localparam int unsigned RW = $clog2(NR + 1);
   localparam int unsigned PW = $clog2(CPR);

   if (!nr_legal(NR) || !cpr_legal(CPR)) begin : g_bad_param
      $error("klein_round_sequencer: NR must be 12/16/20 and CPR 2/4/8/16");
   end

   klein_state_t state_q, state_d;
   logic         in_run;
   logic         cnt_clr;
   logic         phase_wrap;
   logic         round_wrap;
   logic [8:0]   sel;

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:  if (start && !abort) state_d = StRun;
         StRun: begin
            if (abort) begin
               state_d = StIdle;
            end else if (round_wrap) begin
               state_d = StDone;
            end
         end
         StDone:  state_d = (start && !abort) ? StRun : StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge ck) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   assign in_run = (state_q == StRun);
   // Counters sit at zero whenever the next cycle is not a RUN cycle.
   assign cnt_clr = (state_d != StRun);

   klein_mod_counter #(
      .MOD (CPR),
      .W   (PW)
   ) u_phase_cnt (
      .ck    (ck),
      .rst   (rst),
      .clr   (cnt_clr),
      .en    (in_run),
      .count (phase),
      .wrap  (phase_wrap)
   );

   klein_mod_counter #(
      .MOD (NR + 1),
      .W   (RW)
   ) u_round_cnt (
      .ck    (ck),
      .rst   (rst),
      .clr   (cnt_clr),
      .en    (phase_wrap),
      .count (round),
      .wrap  (round_wrap)
   );

   assign sel        = sel_lookup(CPR, 4'(phase));
   assign busy       = in_run;
   assign done       = (state_q == StDone);
   assign round0     = in_run && (round == RW'(0));
   assign round1     = in_run && (round == RW'(1));
   assign last_round = in_run && (round == RW'(NR));
   assign sels       = in_run ? sel[8:5] : '0;
   assign selk       = in_run ? sel[4:0] : '0;

endmodule

// File: tb/tb_klein_round_sequencer.sv
// Directed bench: NR=16/CPR=8 instance for timing, selects, abort and reset; NR=12 and
// NR=20 CPR=4 instances for latency.
module tb_klein_round_sequencer;

   logic ck = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic abort = 1'b0;
   logic start4 = 1'b0;
   logic abort4 = 1'b0;

   logic       busy, done, round0, round1, last_round;
   logic [4:0] round;
   logic [2:0] phase;
   logic [3:0] sels;
   logic [4:0] selk;

   logic       busy12, done12, r0_12, r1_12, lr_12;
   logic [3:0] round12;
   logic [1:0] phase12;
   logic [3:0] sels12;
   logic [4:0] selk12;

   logic       busy20, done20, r0_20, r1_20, lr_20;
   logic [4:0] round20;
   logic [1:0] phase20;
   logic [3:0] sels20;
   logic [4:0] selk20;

   int n_cmp = 0;
   int n_fail = 0;

   logic [3:0] exp_sels [8] = '{4'b0111, 4'b1011, 4'b1001, 4'b0000,
                                4'b0111, 4'b0011, 4'b0001, 4'b0000};
   logic [4:0] exp_selk [8] = '{5'b00000, 5'b01000, 5'b10011, 5'b10010,
                                5'b11100, 5'b10110, 5'b10110, 5'b10110};

   always #5 ck = ~ck;

   klein_round_sequencer #(.NR(16), .CPR(8)) dut (
      .ck(ck), .rst(rst), .start(start), .abort(abort), .busy(busy), .done(done),
      .round(round), .phase(phase), .round0(round0), .round1(round1),
      .last_round(last_round), .sels(sels), .selk(selk)
   );

   klein_round_sequencer #(.NR(12), .CPR(4)) dut12 (
      .ck(ck), .rst(rst), .start(start4), .abort(abort4), .busy(busy12), .done(done12),
      .round(round12), .phase(phase12), .round0(r0_12), .round1(r1_12),
      .last_round(lr_12), .sels(sels12), .selk(selk12)
   );

   klein_round_sequencer #(.NR(20), .CPR(4)) dut20 (
      .ck(ck), .rst(rst), .start(start4), .abort(abort4), .busy(busy20), .done(done20),
      .round(round20), .phase(phase20), .round0(r0_20), .round1(r1_20),
      .last_round(lr_20), .sels(sels20), .selk(selk20)
   );

   task automatic tick();
      @(posedge ck);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b1; abort = 1'b1; start4 = 1'b1;
      tick(); tick();
      n_cmp++;
      if ({busy, done, round, phase} !== 10'b0) begin
         n_fail++;
         $display("FAIL reset_held: busy/done/round/phase got %b %b %0d %0d want 0 0 0 0",
                  busy, done, round, phase);
      end
      n_cmp++;
      if ({busy12, busy20, done12, done20} !== 4'b0) begin
         n_fail++;
         $display("FAIL reset_held_cpr4: busy/done got %b%b%b%b want 0000",
                  busy12, busy20, done12, done20);
      end
      rst = 1'b0; start = 1'b0; abort = 1'b0; start4 = 1'b0;
      tick();
      n_cmp++;
      if ({busy, done, round, phase, round0, round1, last_round, sels, selk} !== 22'b0) begin
         n_fail++;
         $display("FAIL reset_idle: outputs got %b %b %0d %0d %b%b%b %b %b want all zero",
                  busy, done, round, phase, round0, round1, last_round, sels, selk);
      end
   endtask

   task automatic test_latency();
      logic       eb, ed, er0, er1, elr;
      logic [4:0] er;
      logic [2:0] ep;
      logic [3:0] es;
      logic [4:0] ek;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int cyc = 1; cyc <= 140; cyc++) begin
         eb  = (cyc <= 136);
         ed  = (cyc == 137);
         er  = eb ? 5'((cyc - 1) / 8) : 5'd0;
         ep  = eb ? 3'((cyc - 1) % 8) : 3'd0;
         er0 = eb && (cyc <= 8);
         er1 = eb && (cyc >= 9) && (cyc <= 16);
         elr = (cyc >= 129) && (cyc <= 136);
         es  = eb ? exp_sels[ep] : 4'd0;
         ek  = eb ? exp_selk[ep] : 5'd0;
         n_cmp++;
         if ({busy, done, round, phase, round0, round1, last_round, sels, selk} !==
             {eb, ed, er, ep, er0, er1, elr, es, ek}) begin
            n_fail++;
            $display("FAIL latency c%0d: busy/done/round/phase/r0/r1/last/sels/selk got %b %b %0d %0d %b %b %b %b %b want %b %b %0d %0d %b %b %b %b %b",
                     cyc, busy, done, round, phase, round0, round1, last_round, sels, selk,
                     eb, ed, er, ep, er0, er1, elr, es, ek);
         end
         tick();
      end
   endtask

   task automatic test_sel_table();
      start = 1'b1;
      tick();
      // start stays high throughout: RUN must ignore it
      for (int i = 0; i < 24; i++) tick();
      for (int p = 0; p < 8; p++) begin
         n_cmp++;
         if ({busy, round, phase, sels, selk, round0, round1} !==
             {1'b1, 5'd3, 3'(p), exp_sels[p], exp_selk[p], 2'b00}) begin
            n_fail++;
            $display("FAIL sel_table p%0d: busy/round/phase/sels/selk/r0/r1 got %b %0d %0d %b %b %b%b want 1 3 %0d %b %b 00",
                     p, busy, round, phase, sels, selk, round0, round1,
                     p, exp_sels[p], exp_selk[p]);
         end
         tick();
      end
      abort = 1'b1;
      tick();
      n_cmp++;
      if ({busy, done, round, phase} !== 10'b0) begin
         n_fail++;
         $display("FAIL sel_abort_with_start: busy/done/round/phase got %b %b %0d %0d want 0 0 0 0",
                  busy, done, round, phase);
      end
      start = 1'b0; abort = 1'b0;
      tick();
   endtask

   task automatic test_abort();
      int ndone;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 42; i++) tick();
      n_cmp++;
      if ({busy, round, phase} !== {1'b1, 5'd5, 3'd2}) begin
         n_fail++;
         $display("FAIL abort_pre: busy/round/phase got %b %0d %0d want 1 5 2", busy, round, phase);
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      n_cmp++;
      if ({busy, done, round, phase, sels, selk} !== 19'b0) begin
         n_fail++;
         $display("FAIL abort_next: busy/done/round/phase/sels/selk got %b %b %0d %0d %b %b want zeros",
                  busy, done, round, phase, sels, selk);
      end
      ndone = 0;
      for (int i = 0; i < 6; i++) begin
         if (done || busy) ndone++;
         tick();
      end
      n_cmp++;
      if (ndone != 0) begin
         n_fail++;
         $display("FAIL abort_no_done: active cycles got %0d want 0", ndone);
      end
      start = 1'b1; abort = 1'b1;
      tick();
      n_cmp++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_start_abort: busy got %b want 0", busy);
      end
      start = 1'b0; abort = 1'b0;
      tick();
      n_cmp++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_start_abort_after: busy got %b want 0", busy);
      end
   endtask

   task automatic test_back_to_back();
      int ndone, dcyc;
      ndone = 0; dcyc = 0;
      start = 1'b1;
      tick();
      for (int cyc = 1; cyc <= 136; cyc++) begin
         if (done) ndone++;
         tick();
      end
      n_cmp++;
      if ({done, busy} !== 2'b10) begin
         n_fail++;
         $display("FAIL b2b_done: done/busy got %b %b want 1 0", done, busy);
      end
      if (done) ndone++;
      tick();
      n_cmp++;
      if ({busy, done, round, phase} !== {1'b1, 1'b0, 5'd0, 3'd0}) begin
         n_fail++;
         $display("FAIL b2b_relaunch: busy/done/round/phase got %b %b %0d %0d want 1 0 0 0",
                  busy, done, round, phase);
      end
      start = 1'b0;
      for (int cyc = 138; cyc <= 280; cyc++) begin
         if (done) begin
            ndone++;
            dcyc = cyc;
         end
         tick();
      end
      n_cmp++;
      if (ndone != 2) begin
         n_fail++;
         $display("FAIL b2b_done_count: got %0d want 2", ndone);
      end
      n_cmp++;
      if (dcyc != 274) begin
         n_fail++;
         $display("FAIL b2b_second_done: cycle got %0d want 274", dcyc);
      end
   endtask

   task automatic test_reset_mid();
      int ndone, dcyc;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 72; i++) tick();
      n_cmp++;
      if ({busy, round} !== {1'b1, 5'd9}) begin
         n_fail++;
         $display("FAIL rst_mid_pre: busy/round got %b %0d want 1 9", busy, round);
      end
      rst = 1'b1;
      tick();
      n_cmp++;
      if ({busy, done, round, phase, round0, round1, last_round, sels, selk} !== 22'b0) begin
         n_fail++;
         $display("FAIL rst_mid: outputs got %b %b %0d %0d %b%b%b %b %b want all zero",
                  busy, done, round, phase, round0, round1, last_round, sels, selk);
      end
      rst = 1'b0;
      tick();
      ndone = 0; dcyc = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int cyc = 1; cyc <= 140; cyc++) begin
         if (done) begin
            ndone++;
            if (dcyc == 0) dcyc = cyc;
         end
         tick();
      end
      n_cmp++;
      if (ndone != 1 || dcyc != 137) begin
         n_fail++;
         $display("FAIL rst_relaunch: done count/cycle got %0d %0d want 1 137", ndone, dcyc);
      end
   endtask

   task automatic test_nr12_20();
      int d12, d20, n12, n20;
      d12 = 0; d20 = 0; n12 = 0; n20 = 0;
      start4 = 1'b1;
      tick();
      start4 = 1'b0;
      for (int cyc = 1; cyc <= 90; cyc++) begin
         if (cyc == 21) begin
            n_cmp++;
            if ({busy12, round12, phase12, busy20, round20, phase20} !==
                {1'b1, 4'd5, 2'd0, 1'b1, 5'd5, 2'd0}) begin
               n_fail++;
               $display("FAIL cpr4_start_ignored: r12/p12 %0d %0d r20/p20 %0d %0d want 5 0 5 0",
                        round12, phase12, round20, phase20);
            end
         end
         if (cyc == 52) begin
            n_cmp++;
            if ({busy12, last_round, lr_12} !== 3'b101) begin
               n_fail++;
               $display("FAIL nr12_last: busy12/last_round(16)/last12 got %b %b %b want 1 0 1",
                        busy12, last_round, lr_12);
            end
         end
         if (done12) begin n12++; if (d12 == 0) d12 = cyc; end
         if (done20) begin n20++; if (d20 == 0) d20 = cyc; end
         start4 = (cyc == 20);
         tick();
      end
      start4 = 1'b0;
      n_cmp++;
      if (n12 != 1 || d12 != 53) begin
         n_fail++;
         $display("FAIL nr12_latency: done count/cycle got %0d %0d want 1 53", n12, d12);
      end
      n_cmp++;
      if (n20 != 1 || d20 != 85) begin
         n_fail++;
         $display("FAIL nr20_latency: done count/cycle got %0d %0d want 1 85", n20, d20);
      end
   endtask

   initial begin
      test_reset();
      test_latency();
      test_sel_table();
      test_abort();
      test_back_to_back();
      test_reset_mid();
      test_nr12_20();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
